// File: rtl/seq_divider_32bits_pkg.sv
// Shared constants for the sequential restoring divider: state encoding,
// default widths and the divide-by-zero quotient pattern.
package seq_divider_32bits_pkg;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_CNT_W = 6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    ZERO = 2'd3
  } state_t;

  localparam logic [DEF_WIDTH-1:0] DIV_ZERO_Q = 32'hFFFFFFFF;

endpackage

// File: rtl/seq_divider_32bits_if.sv
// Request/result bundle between the control unit (master) and the divider (slave).
interface seq_divider_32bits_if
  import seq_divider_32bits_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
);

  // Handshake: start is taken only while busy=0 (divider in IDLE); starts seen
  // while busy=1 are dropped. done pulses for one cycle when quotient,
  // remainder and div_zero become valid; those stay held until the next done.
  logic             start;
  logic             is_signed;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_zero;
  state_t           dbg_state;

  modport master (
    output start, is_signed, dividend, divisor,
    input  busy, done, quotient, remainder, div_zero, dbg_state
  );

  modport slave (
    input  start, is_signed, dividend, divisor,
    output busy, done, quotient, remainder, div_zero, dbg_state
  );

endinterface

// File: rtl/seq_divider_32bits_div_sub_step.sv
// One restoring-division step: shift in a dividend bit, trial-subtract the
// divisor with an inverted-B add, keep the difference when no borrow occurs.
module seq_divider_32bits_div_sub_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH:0]   p_in,
  input  logic             shift_bit,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH:0]   p_out,
  output logic             q_bit
);

  logic [WIDTH:0]   p_sh;
  logic [WIDTH+1:0] sum;

  assign p_sh = {p_in[WIDTH-1:0], shift_bit};
  // Carry-out of the 33-bit add is the inverse of the borrow.
  assign sum   = {1'b0, p_sh} + {1'b0, ~{1'b0, d}} + {{(WIDTH+1){1'b0}}, 1'b1};
  assign q_bit = sum[WIDTH+1];
  assign p_out = q_bit ? sum[WIDTH:0] : p_sh;

endmodule

// File: rtl/seq_divider_32bits.sv
// Multi-cycle signed/unsigned restoring divider: one trial subtraction per
// clock, sign fix-up in a final cycle, short path for a zero divisor.
module seq_divider_32bits
  import seq_divider_32bits_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input logic                clk,
  input logic                rst,
  seq_divider_32bits_if.slave bus
);

  localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WIDTH);

  state_t           state, state_nxt;
  logic [WIDTH:0]   p_r, p_nxt;
  logic [WIDTH-1:0] q_r, d_r;
  logic [CNT_W-1:0] cnt_r;
  logic             qneg_r, rneg_r, q_bit;
  logic             sa, sb;
  logic [WIDTH-1:0] a_mag, b_mag, q_fix, r_fix;

  assign sa    = bus.is_signed & bus.dividend[WIDTH-1];
  assign sb    = bus.is_signed & bus.divisor[WIDTH-1];
  assign a_mag = sa ? (~bus.dividend + ONE) : bus.dividend;
  assign b_mag = sb ? (~bus.divisor + ONE) : bus.divisor;
  assign q_fix = qneg_r ? (~q_r + ONE) : q_r;
  assign r_fix = rneg_r ? (~p_r[WIDTH-1:0] + ONE) : p_r[WIDTH-1:0];

  assign bus.dbg_state = state;

  seq_divider_32bits_div_sub_step #(.WIDTH(WIDTH)) u_step (
    .p_in      (p_r),
    .shift_bit (q_r[WIDTH-1]),
    .d         (d_r),
    .p_out     (p_nxt),
    .q_bit     (q_bit)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (bus.start) state_nxt = (bus.divisor == '0) ? ZERO : CALC;
      CALC:    if (cnt_r == CNT_ONE) state_nxt = FIX;
      FIX:     state_nxt = IDLE;
      ZERO:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      p_r           <= '0;
      q_r           <= '0;
      d_r           <= '0;
      cnt_r         <= '0;
      qneg_r        <= 1'b0;
      rneg_r        <= 1'b0;
      bus.busy      <= 1'b0;
      bus.done      <= 1'b0;
      bus.quotient  <= '0;
      bus.remainder <= '0;
      bus.div_zero  <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            bus.busy <= 1'b1;
            if (bus.divisor != '0) begin
              p_r    <= '0;
              q_r    <= a_mag;
              d_r    <= b_mag;
              cnt_r  <= CNT_INIT;
              qneg_r <= sa ^ sb;
              rneg_r <= sa;
            end else begin
              // Zero divisor: the raw dividend is returned as the remainder.
              q_r <= bus.dividend;
            end
          end
        end
        CALC: begin
          p_r   <= p_nxt;
          q_r   <= {q_r[WIDTH-2:0], q_bit};
          cnt_r <= cnt_r - CNT_ONE;
        end
        FIX: begin
          bus.quotient  <= q_fix;
          bus.remainder <= r_fix;
          bus.div_zero  <= 1'b0;
          bus.done      <= 1'b1;
          bus.busy      <= 1'b0;
        end
        ZERO: begin
          bus.quotient  <= DIV_ZERO_Q;
          bus.remainder <= q_r;
          bus.div_zero  <= 1'b1;
          bus.done      <= 1'b1;
          bus.busy      <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider_32bits.sv
// Directed bench for seq_divider_32bits: hand-computed vectors, latency and
// busy-window checks, start-while-busy and mid-operation reset.
module tb_seq_divider_32bits;
  import seq_divider_32bits_pkg::*;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;
  logic [64:0] exp_q[$];

  seq_divider_32bits_if #(.WIDTH(DEF_WIDTH)) bus ();

  seq_divider_32bits #(.WIDTH(DEF_WIDTH), .CNT_W(DEF_CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [64:0] got, input logic [64:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // inj_kind: 0 none, 1 second start at inj_cyc, 2 reset at inj_cyc
  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic sgn, input logic [31:0] eq, input logic [31:0] er,
                        input logic ez, input int exp_lat, input int inj_cyc, input int inj_kind);
    int cyc;
    int busy_n;
    bit seen;
    logic [64:0] exp_v;
    if (inj_kind != 2) exp_q.push_back({ez, eq, er});
    @(negedge clk);
    bus.start     = 1'b1;
    bus.dividend  = a;
    bus.divisor   = b;
    bus.is_signed = sgn;
    @(posedge clk); #1;
    bus.start = 1'b0;
    cyc    = 0;
    busy_n = 0;
    seen   = 0;
    while (cyc < 60) begin
      if (bus.done) begin
        seen = 1;
        break;
      end
      if (bus.busy) busy_n++;
      bus.start = 1'b0;
      if (inj_kind == 1 && cyc == inj_cyc) begin
        bus.start     = 1'b1;
        bus.dividend  = 32'h0000DEAD;
        bus.divisor   = 32'd3;
        bus.is_signed = 1'b0;
      end
      if (inj_kind == 2 && cyc == inj_cyc) begin
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check_val({tag, "_rst_busy"}, 65'(bus.busy), 65'd0);
        check_val({tag, "_rst_done"}, 65'(bus.done), 65'd0);
        check_val({tag, "_rst_res"}, {bus.div_zero, bus.quotient, bus.remainder}, 65'd0);
        check_val({tag, "_rst_state"}, 65'(bus.dbg_state), 65'(IDLE));
        for (int i = 0; i < 40; i++) begin
          if (bus.done) seen = 1;
          @(posedge clk); #1;
        end
        check_val({tag, "_no_done"}, 65'(seen), 65'd0);
        return;
      end
      @(posedge clk); #1;
      cyc++;
    end
    bus.start = 1'b0;
    check_val({tag, "_done_seen"}, 65'(seen), 65'd1);
    check_val({tag, "_latency"}, 65'(cyc), 65'(exp_lat));
    check_val({tag, "_busy_cycles"}, 65'(busy_n), 65'(exp_lat));
    check_val({tag, "_busy_at_done"}, 65'(bus.busy), 65'd0);
    exp_v = exp_q.pop_front();
    if (seen) check_val({tag, "_result"}, {bus.div_zero, bus.quotient, bus.remainder}, exp_v);
    @(posedge clk); #1;
    check_val({tag, "_done_pulse"}, 65'(bus.done), 65'd0);
    check_val({tag, "_held"}, {bus.div_zero, bus.quotient, bus.remainder}, exp_v);
  endtask

  initial begin
    n_checks      = 0;
    n_fail        = 0;
    rst           = 1'b1;
    bus.start     = 1'b0;
    bus.is_signed = 1'b0;
    bus.dividend  = '0;
    bus.divisor   = '0;
    repeat (3) @(posedge clk);
    #1;
    check_val("reset_busy", 65'(bus.busy), 65'd0);
    check_val("reset_done", 65'(bus.done), 65'd0);
    check_val("reset_res", {bus.div_zero, bus.quotient, bus.remainder}, 65'd0);
    check_val("reset_state", 65'(bus.dbg_state), 65'(IDLE));
    rst = 1'b0;
    @(posedge clk); #1;

    run_op("u_100_7",    32'd100,        32'd7,          1'b0, 32'd14,         32'd2,          1'b0, 33, 0, 0);
    run_op("s_m100_7",   32'hFFFFFF9C,   32'd7,          1'b1, 32'hFFFFFFF2,   32'hFFFFFFFE,   1'b0, 33, 0, 0);
    run_op("s_100_m7",   32'd100,        32'hFFFFFFF9,   1'b1, 32'hFFFFFFF2,   32'd2,          1'b0, 33, 0, 0);
    run_op("u_max_1",    32'hFFFFFFFF,   32'd1,          1'b0, 32'hFFFFFFFF,   32'd0,          1'b0, 33, 0, 0);
    run_op("u_max_max",  32'hFFFFFFFF,   32'hFFFFFFFF,   1'b0, 32'd1,          32'd0,          1'b0, 33, 0, 0);
    run_op("u_5_9",      32'd5,          32'd9,          1'b0, 32'd0,          32'd5,          1'b0, 33, 0, 0);
    run_op("u_div0",     32'h000004D2,   32'd0,          1'b0, 32'hFFFFFFFF,   32'h000004D2,   1'b1, 1,  0, 0);
    run_op("s_div0",     32'h000004D2,   32'd0,          1'b1, 32'hFFFFFFFF,   32'h000004D2,   1'b1, 1,  0, 0);
    run_op("s_neg_div0", 32'hFFFFFF9C,   32'd0,          1'b1, 32'hFFFFFFFF,   32'hFFFFFF9C,   1'b1, 1,  0, 0);
    run_op("clr_dz",     32'd100,        32'd7,          1'b0, 32'd14,         32'd2,          1'b0, 33, 0, 0);
    run_op("s_ovf",      32'h80000000,   32'hFFFFFFFF,   1'b1, 32'h80000000,   32'd0,          1'b0, 33, 0, 0);
    run_op("s_m7_m2",    32'hFFFFFFF9,   32'hFFFFFFFE,   1'b1, 32'd3,          32'hFFFFFFFF,   1'b0, 33, 0, 0);
    run_op("restart",    32'd100,        32'd7,          1'b0, 32'd14,         32'd2,          1'b0, 33, 5, 1);
    run_op("mid_rst",    32'd1000,       32'd10,         1'b0, 32'd100,        32'd0,          1'b0, 33, 10, 2);
    run_op("after_rst",  32'd1000,       32'd10,         1'b0, 32'd100,        32'd0,          1'b0, 33, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
